// File: rtl/result_tx_pkg.sv
// Shared types and constants for result_frame_tx.
// RESULT_TX_CKSUM_EN selects 7-byte frames with a trailing XOR checksum; otherwise frames are 6 bytes.
package result_tx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef RESULT_TX_CKSUM_EN
    localparam int FRAME_BYTES = 7;
`else
    localparam int FRAME_BYTES = 6;
`endif

    typedef logic signed [31:0] q16_16_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_D3,
        ST_D2,
        ST_D1,
        ST_D0,
        ST_GAP
`ifdef RESULT_TX_CKSUM_EN
        , ST_CKSUM
`endif
    } tx_state_t;

    // Selects one byte of the word, idx 3 = MSB.
    function automatic logic [7:0] word_byte(input q16_16_t w, input logic [1:0] idx);
        logic [31:0] u;
        u = w;
        return u[8*idx +: 8];
    endfunction

endpackage

// File: rtl/result_frame_tx.sv
// Serializes one Q16.16 result per handshake into SYNC, SEQ, D3..D0 [, CKSUM] bytes.
// Build option RESULT_TX_CKSUM_EN appends the XOR checksum byte.
module result_frame_tx
    import result_tx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned IDLE_GAP  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  q16_16_t     in_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic [15:0] frames_sent
);

    localparam logic [7:0] GAP_LOAD = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

`ifdef RESULT_TX_CKSUM_EN
    localparam tx_state_t LAST_ST = ST_CKSUM;
`else
    localparam tx_state_t LAST_ST = ST_D0;
`endif

    tx_state_t   state_q, state_d;
    q16_16_t     word_q, word_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] frames_q, frames_d;
    logic [7:0]  gap_q, gap_d;
`ifdef RESULT_TX_CKSUM_EN
    logic [7:0]  cksum_q, cksum_d;
`endif

    logic        byte_valid;
    logic [7:0]  byte_data;

    // Byte presented for the current state; held steady because state and word only move on a handshake.
    always_comb begin
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        case (state_q)
            ST_SYNC:  byte_data = SYNC_BYTE;
            ST_SEQ:   byte_data = seq_q;
            ST_D3:    byte_data = word_byte(word_q, 2'd3);
            ST_D2:    byte_data = word_byte(word_q, 2'd2);
            ST_D1:    byte_data = word_byte(word_q, 2'd1);
            ST_D0:    byte_data = word_byte(word_q, 2'd0);
`ifdef RESULT_TX_CKSUM_EN
            ST_CKSUM: byte_data = cksum_q;
`endif
            default:  byte_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        seq_d    = seq_q;
        frames_d = frames_q;
        gap_d    = gap_q;
`ifdef RESULT_TX_CKSUM_EN
        cksum_d  = cksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    state_d = ST_SYNC;
`ifdef RESULT_TX_CKSUM_EN
                    cksum_d = seq_q;
`endif
                end
            end
            ST_SYNC: if (tx_ready) state_d = ST_SEQ;
            ST_SEQ:  if (tx_ready) state_d = ST_D3;
            ST_D3:   if (tx_ready) state_d = ST_D2;
            ST_D2:   if (tx_ready) state_d = ST_D1;
            ST_D1:   if (tx_ready) state_d = ST_D0;
`ifdef RESULT_TX_CKSUM_EN
            ST_D0:   if (tx_ready) state_d = ST_CKSUM;
`endif
            ST_GAP: begin
                if (gap_q == 8'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: ;
        endcase

`ifdef RESULT_TX_CKSUM_EN
        // Data bytes fold into the checksum as they leave; SEQ was seeded at acceptance.
        if (tx_ready && (state_q == ST_D3 || state_q == ST_D2 ||
                         state_q == ST_D1 || state_q == ST_D0))
            cksum_d = cksum_q ^ byte_data;
`endif

        if (state_q == LAST_ST && tx_ready) begin
            seq_d    = seq_q + 8'd1;
            frames_d = frames_q + 16'd1;
            if (IDLE_GAP > 0) begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            seq_q    <= 8'd0;
            frames_q <= 16'd0;
            gap_q    <= 8'd0;
`ifdef RESULT_TX_CKSUM_EN
            cksum_q  <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            seq_q    <= seq_d;
            frames_q <= frames_d;
            gap_q    <= gap_d;
`ifdef RESULT_TX_CKSUM_EN
            cksum_q  <= cksum_d;
`endif
        end
    end

    // Outputs are quiet while reset is held, whatever state was left over.
    assign in_ready    = !rst && (state_q == ST_IDLE);
    assign tx_valid    = !rst && byte_valid;
    assign tx_data     = rst ? 8'h00 : byte_data;
    assign tx_last     = !rst && (state_q == LAST_ST);
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_result_frame_tx.sv
// Scoreboard bench for result_frame_tx; follows RESULT_TX_CKSUM_EN for expected frame length.
module tb_result_frame_tx;

    localparam logic [7:0] SYNC = 8'hA5;
`ifdef RESULT_TX_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic signed [31:0] in_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic [15:0] frames_sent;

    logic        g_in_valid;
    logic        g_in_ready;
    logic signed [31:0] g_in_data;
    logic        g_tx_valid;
    logic        g_tx_ready;
    logic [7:0]  g_tx_data;
    logic        g_tx_last;
    logic [15:0] g_frames_sent;

    always #5 clk = ~clk;

    result_frame_tx #(.SYNC_BYTE(8'hA5), .IDLE_GAP(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .frames_sent(frames_sent)
    );

    result_frame_tx #(.SYNC_BYTE(8'hA5), .IDLE_GAP(3)) u_gap (
        .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready), .in_data(g_in_data),
        .tx_valid(g_tx_valid), .tx_ready(g_tx_ready), .tx_data(g_tx_data), .tx_last(g_tx_last),
        .frames_sent(g_frames_sent)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0]  exp_q[$];
    logic [7:0]  seq_model = 8'd0;
    logic [15:0] frames_model = 16'd0;
    int          byte_idx = 0;
    int          mode = 0;
    int          stall_cnt = 0;
    bit          hold_v = 1'b0;
    logic [7:0]  hold_data = 8'd0;
    logic        hold_last = 1'b0;
    bit          post_last = 1'b0;
    logic [7:0]  g_seq = 8'd0;
    logic [15:0] g_frames = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_cksum(input logic [7:0] s, input logic [31:0] w);
        return s ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    task automatic push_frame(input logic [31:0] w);
        logic [7:0] b[6];
        b[0] = SYNC;       b[1] = seq_model;
        b[2] = w[31:24];   b[3] = w[23:16];
        b[4] = w[15:8];    b[5] = w[7:0];
        for (int i = 0; i < 6; i++)
            exp_q.push_back({(!CK && i == 5), b[i]});
        if (CK) exp_q.push_back({1'b1, frame_cksum(seq_model, w)});
        seq_model = seq_model + 8'd1;
    endtask

    // tx_ready patterns: 0 always ready, 1 random, 2 random with a 5-cycle stall on D2, 3 stop at D1.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            2: begin
                if (byte_idx == 3 && stall_cnt < 5) begin
                    tx_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    tx_ready = 1'($urandom_range(0, 1));
                end
            end
            default: tx_ready = (byte_idx < 4);
        endcase
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            hold_v    = 1'b0;
            post_last = 1'b0;
        end else begin
            if (post_last) begin
                post_last = 1'b0;
                check_eq("in_ready_after_last", in_ready, 1);
                check_eq("frames_sent", frames_sent, frames_model);
            end
            if (hold_v) begin
                check_eq("stall_valid", tx_valid, 1);
                check_eq("stall_data", tx_data, hold_data);
                check_eq("stall_last", tx_last, hold_last);
            end
            if (tx_valid) begin
                check_eq("in_ready_busy", in_ready, 0);
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_byte", tx_data, 9'h1FF);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("byte", tx_data, e[7:0]);
                        check_eq("last", tx_last, e[8]);
                        if (e[8]) begin
                            byte_idx = 0;
                            frames_model = frames_model + 16'd1;
                            post_last = 1'b1;
                        end else begin
                            byte_idx++;
                        end
                    end
                end
            end
            hold_v    = tx_valid && !tx_ready;
            hold_data = tx_data;
            hold_last = tx_last;
        end
    end

    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        int n = 0;
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = w;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            check_eq("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        $display("tx word %h seq %0d", w, seq_model);
        push_frame(w);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = $urandom;
        @(negedge clk);
        check_eq("sync_lat_valid", tx_valid, 1);
        check_eq("sync_lat_data", tx_data, SYNC);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", (n < 2000), 1);
    endtask

    task automatic gap_frame(input logic [31:0] w);
        bit ok = 1'b0;
        int n = 0;
        logic [7:0] exp_last;
        @(posedge clk);
        #1 g_in_valid = 1'b1;
        g_in_data = w;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (g_in_ready) ok = 1'b1;
            else n++;
        end
        @(posedge clk);
        #1 g_in_valid = 1'b0;
        if (!ok) begin
            check_eq("gap_accept_timeout", 0, 1);
            return;
        end
        $display("gap word %h seq %0d", w, g_seq);
        ok = 1'b0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (g_tx_valid && g_tx_last) ok = 1'b1;
            else n++;
        end
        check_eq("gap_last_seen", ok, 1);
        if (!ok) return;
        exp_last = CK ? frame_cksum(g_seq, w) : w[7:0];
        check_eq("gap_last_byte", g_tx_data, exp_last);
        g_seq = g_seq + 8'd1;
        g_frames = g_frames + 16'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("gap_tx_valid", g_tx_valid, 0);
            check_eq("gap_in_ready", g_in_ready, 0);
        end
        @(negedge clk);
        check_eq("gap_ready_back", g_in_ready, 1);
        check_eq("gap_frames", g_frames_sent, g_frames);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        tx_ready = 1'b1;
        g_in_valid = 1'b0;
        g_in_data = '0;
        g_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_tx_last", tx_last, 0);
        check_eq("rst_frames", frames_sent, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", in_ready, 1);

        send_word(32'h0001_8000);
        wait_idle();
        send_word(32'hFFFF_0000);
        wait_idle();

        mode = 1;
        for (int i = 0; i < 3; i++) send_word($urandom);
        wait_idle();
        stall_cnt = 0;
        mode = 2;
        send_word(32'h0001_8000);
        wait_idle();
        check_eq("stall_applied", stall_cnt, 5);
        mode = 1;
        send_word(32'h7FFF_FFFF);
        wait_idle();
        mode = 0;

        // Abandon a frame while D1 is on the bus.
        mode = 3;
        send_word(32'h1234_5678);
        begin
            bit ok = 1'b0;
            int n = 0;
            while (!ok && n < 50) begin
                @(negedge clk);
                if (tx_valid && byte_idx == 4 && !tx_ready) ok = 1'b1;
                else n++;
            end
            check_eq("d1_reached", ok, 1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        mode = 0;
        exp_q.delete();
        byte_idx = 0;
        seq_model = 8'd0;
        frames_model = 16'd0;
        @(negedge clk);
        check_eq("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_tx_valid", tx_valid, 0);
        check_eq("midrst_in_ready_back", in_ready, 1);
        check_eq("midrst_frames", frames_sent, 0);

        send_word(32'hDEAD_BEEF);
        for (int i = 0; i < 256; i++) send_word($urandom);
        wait_idle();
        check_eq("burst_frames", frames_sent, 257);

        gap_frame(32'h0001_8000);
        gap_frame(32'hFFFF_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
